// File: rtl/seg7_pkg.sv
// Shared constants and types for the front-panel 7-segment driver.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] COM_OFF   = 8'hFF;

  // Segment order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       key0;
    logic [7:0] dip;
    logic [3:0] rotary;
  } panel_t;

  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_HEX = 1'b1
  } mode_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to 7-segment glyph decoder.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TBL[val];

endmodule

// File: rtl/seg7_disp.sv
// 8-digit multiplexed 7-segment driver: hex (rotary) or binary (DIP) mode.
// Latency: SYNC_STG+1 cycles from input pin to segment/common outputs.
// Backpressure: none; display free-runs at SCAN_DIV cycles per digit.
module seg7_disp
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int SYNC_STG = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_key0,
  input  logic [7:0] i_dip,
  input  logic [3:0] i_rotary,
  output logic [7:0] o_seg_d,
  output logic [7:0] o_seg_com
);

  localparam int              DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam panel_t          PANEL_RST = '{key0: 1'b1, dip: 8'h00, rotary: 4'h0};

  panel_t                    panel_in;
  panel_t                    panel_s;
  panel_t [SYNC_STG-1:0]     sync_q;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             run_q, run_d;
  logic             tick;
  mode_t            mode;
  logic [3:0]       dec_in;
  logic [6:0]       glyph;
  logic [7:0]       seg_d, com_d;

  assign panel_in = '{key0: i_key0, dip: i_dip, rotary: i_rotary};
  assign panel_s  = sync_q[SYNC_STG-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= {SYNC_STG{PANEL_RST}};
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], panel_in};
    end
  end

  // run_q stays low until the first terminal count so digit 0 is the first one lit.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    run_d = run_q | tick;
    idx_d = (tick && run_q) ? idx_q + 3'd1 : idx_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      div_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

  assign mode   = panel_s.key0 ? MODE_HEX : MODE_BIN;
  assign dec_in = (mode == MODE_HEX) ? panel_s.rotary : {3'b000, panel_s.dip[idx_d]};

  seg7_hex_dec u_dec (
    .val   (dec_in),
    .glyph (glyph)
  );

  // Content is built for idx_d so segments and common change on the same edge.
  always_comb begin
    seg_d = SEG_BLANK;
    com_d = COM_OFF;
    if (run_d) begin
      com_d = ~(8'b1 << idx_d);
      case (mode)
        MODE_HEX: seg_d = panel_s.dip[idx_d] ? {1'b0, glyph} : SEG_BLANK;
        MODE_BIN: seg_d = {(idx_d == panel_s.rotary[2:0]), glyph};
        default:  seg_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_seg_d   <= SEG_BLANK;
      o_seg_com <= COM_OFF;
    end else begin
      o_seg_d   <= seg_d;
      o_seg_com <= com_d;
    end
  end

endmodule

// File: tb/tb_seg7_disp.sv
// Testbench for seg7_disp: directed and random panel settings against a cycle-count reference model.
module tb_seg7_disp;

  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key0 = 1'b1;
  logic [7:0] dip = 8'h00;
  logic [3:0] rot = 4'h0;
  logic [7:0] seg_d, seg_com;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  seg7_disp #(.SCAN_DIV(S), .SYNC_STG(2)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_key0    (key0),
    .i_dip     (dip),
    .i_rotary  (rot),
    .o_seg_d   (seg_d),
    .o_seg_com (seg_com)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) n = 0;
    else n = n + 1;
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int digit_at(input int cyc);
    if (cyc < S) return -1;
    return (cyc / S - 1) % 8;
  endfunction

  function automatic logic [7:0] exp_com(input int cyc);
    int d;
    d = digit_at(cyc);
    if (d < 0) return 8'hFF;
    return 8'hFF ^ (8'd1 << d);
  endfunction

  function automatic logic [7:0] exp_seg(input int cyc, input logic k,
                                         input logic [7:0] dp, input logic [3:0] r);
    int d;
    d = digit_at(cyc);
    if (d < 0) return 8'h00;
    if (k) return dp[d] ? {1'b0, glyph(r)} : 8'h00;
    return {(d == int'(r[2:0])), glyph({3'b000, dp[d]})};
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, expv);
    end
  endtask

  task automatic check_cycles(input int cnt, input string tag);
    repeat (cnt) begin
      @(negedge clk);
      cmp({tag, "_com"}, seg_com, exp_com(n));
      cmp({tag, "_seg"}, seg_d, exp_seg(n, key0, dip, rot));
    end
  endtask

  task automatic apply(input logic k, input logic [7:0] dp, input logic [3:0] r);
    @(negedge clk);
    key0 = k;
    dip  = dp;
    rot  = r;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset held: outputs blank.
    key0 = 1'b1; dip = 8'h01; rot = 4'h5;
    repeat (5) @(negedge clk);
    cmp("rst_com", seg_com, 8'hFF);
    cmp("rst_seg", seg_d, 8'h00);

    // Release and watch the first frames, including the pre-first-tick window.
    rstn = 1'b1;
    check_cycles(2 * 8 * S + S, "hex_5_dip01");

    apply(1'b1, 8'hFF, 4'hA);
    check_cycles(8 * S, "hex_A_all");

    for (int v = 0; v < 16; v++) begin
      apply(1'b1, 8'hFF, v[3:0]);
      check_cycles(2 * S, "hex_sweep");
    end

    apply(1'b0, 8'h80, 4'h3);
    check_cycles(8 * S, "bin_dip80_r3");

    apply(1'b0, 8'h80, 4'hF);
    check_cycles(8 * S, "bin_rF");

    for (int b = 0; b < 8; b++) begin
      apply(1'b0, 8'd1 << b, 4'hF);
      check_cycles(8 * S, "bin_walk");
    end

    // Random settings, changed at arbitrary points within a slot.
    for (int t = 0; t < 40; t++) begin
      apply(1'($urandom), 8'($urandom), 4'($urandom));
      check_cycles(int'($urandom_range(S, 8 * S)), "rand");
    end

    // Asynchronous reset in the middle of a frame.
    apply(1'b1, 8'hFF, 4'h7);
    repeat (3 * S + 3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    cmp("arst_com", seg_com, 8'hFF);
    cmp("arst_seg", seg_d, 8'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check_cycles(8 * S + S, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
